cfg_loader: RTL and testbench

- Configuration sequencer that feeds the fabric configuration chain (`cfg_i` of the top-level `s3ga`) from a host word stream.
- Host words arrive CFG_W bits at a time over a valid/ready handshake. Each frame is delimited by `in_last`.
- The chain's config RAMs consume one segment per cycle with no backpressure. A frame must therefore reach the chain contiguously once its start marker has been sent.
- The block buffers each whole frame, emits the start marker (value 1), then streams the frame without gaps. It counts frames and reports done or error.

---
 rtl/cfg_loader_pkg.sv | 16 +
 rtl/cfg_loader_fifo.sv | 68 ++++++
 rtl/cfg_loader.sv | 143 ++++++++++++++
 tb/tb_cfg_loader.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_loader_pkg.sv
// Shared types for the configuration loader: controller state encoding.
package cfg_loader_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSend = 2'd1,
        StDone = 2'd2,
        StErr  = 2'd3
    } cl_state_e;

    // Value driven on the chain to announce the start of a frame.
    function automatic logic [31:0] start_marker();
        return 32'd1;
    endfunction

endpackage

// File: rtl/cfg_loader_fifo.sv
// Synchronous frame buffer with registered full/empty flags; push and pop may share a cycle.
module cfg_fifo #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, empty_q;
    logic             do_push, do_pop;

    // A slot freed by a same-cycle pop is not reusable until the count register updates.
    assign do_push = push && !full_q;
    assign do_pop  = pop && !empty_q;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/cfg_loader.sv
// Buffers whole host frames, then streams marker plus frame gap-free into the fabric config chain.
module cfg_loader
    import cfg_loader_pkg::*;
#(
    parameter int unsigned CFG_W    = 4,
    parameter int unsigned FIFO_D   = 64,
    parameter int unsigned N_FRAMES = 16,
    parameter int unsigned CNT_W    = $clog2(N_FRAMES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CFG_W-1:0] in_data,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [CFG_W-1:0] cfg_o,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] frames_sent
);

    localparam int unsigned     BUF_W    = $clog2(FIFO_D + 1);
    localparam logic [CNT_W-1:0] NFrames  = CNT_W'(N_FRAMES);
    localparam logic [CNT_W-1:0] LastIdx  = CNT_W'(N_FRAMES - 1);

    cl_state_e        state_q, state_d;
    logic [CFG_W-1:0] cfg_q, cfg_d;
    logic             marker_q, marker_d;
    logic             was_send_q;
    logic [BUF_W-1:0] frames_buf_q, frames_buf_d;
    logic [CNT_W-1:0] frames_sent_q, frames_sent_d;
    logic [CNT_W-1:0] frames_in_q, frames_in_d;

    logic             push, pop, pop_last, push_last;
    logic             fifo_full, fifo_empty;
    logic [CFG_W:0]   fifo_rdata;

    assign in_ready = !rst && (state_q == StIdle || state_q == StSend) && !fifo_full
                      && (frames_in_q < NFrames);
    assign push      = in_valid && in_ready;
    assign push_last = push && in_last;
    assign pop_last  = pop && fifo_rdata[CFG_W];

    cfg_fifo #(
        .WIDTH (CFG_W + 1),
        .DEPTH (FIFO_D)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({in_last, in_data}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        cfg_d    = '0;
        marker_d = 1'b0;
        pop      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (fifo_full && frames_buf_q == '0) begin
                    state_d = StErr;
                end else if (frames_buf_q != '0 && !was_send_q) begin
                    // One quiet cycle separates the last word of a frame from the next marker.
                    cfg_d    = CFG_W'(start_marker());
                    marker_d = 1'b1;
                    state_d  = StSend;
                end
            end
            StSend: begin
                pop   = 1'b1;
                cfg_d = fifo_rdata[CFG_W-1:0];
                if (fifo_rdata[CFG_W]) begin
                    state_d = (frames_sent_q == LastIdx) ? StDone : StIdle;
                end
            end
            StDone, StErr: begin
                state_d = state_q;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        frames_buf_d = frames_buf_q;
        if (push_last && !pop_last) begin
            frames_buf_d = frames_buf_q + 1'b1;
        end else if (!push_last && pop_last) begin
            frames_buf_d = frames_buf_q - 1'b1;
        end

        frames_sent_d = frames_sent_q;
        if (pop_last && frames_sent_q < NFrames) begin
            frames_sent_d = frames_sent_q + 1'b1;
        end

        frames_in_d = frames_in_q;
        if (push_last) begin
            frames_in_d = frames_in_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            cfg_q         <= '0;
            marker_q      <= 1'b0;
            was_send_q    <= 1'b0;
            frames_buf_q  <= '0;
            frames_sent_q <= '0;
            frames_in_q   <= '0;
        end else begin
            state_q       <= state_d;
            cfg_q         <= cfg_d;
            marker_q      <= marker_d;
            was_send_q    <= (state_q == StSend);
            frames_buf_q  <= frames_buf_d;
            frames_sent_q <= frames_sent_d;
            frames_in_q   <= frames_in_d;
        end
    end

    // The whole frame is buffered before its marker, so SEND never finds the buffer empty.
    always_ff @(posedge clk) begin
        if (!rst && state_q == StSend) begin
            assert (!fifo_empty);
        end
    end

    assign cfg_o       = cfg_q;
    assign busy        = (state_q == StSend) || marker_q;
    assign done        = (state_q == StDone);
    assign err         = (state_q == StErr);
    assign frames_sent = frames_sent_q;

endmodule

// File: tb/tb_cfg_loader.sv
// Randomised bench for cfg_loader against a frame-schedule model, plus directed literal checks.
module tb_cfg_loader;

    localparam int CFG_W    = 4;
    localparam int FIFO_D   = 8;
    localparam int N_FRAMES = 4;
    localparam int CNT_W    = $clog2(N_FRAMES + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [CFG_W-1:0] in_data = '0;
    logic             in_last = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [CFG_W-1:0] cfg_o;
    logic             busy, done, err;
    logic [CNT_W-1:0] frames_sent;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cfg_loader #(
        .CFG_W    (CFG_W),
        .FIFO_D   (FIFO_D),
        .N_FRAMES (N_FRAMES),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .cfg_o       (cfg_o),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .frames_sent (frames_sent)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: each completed frame is scheduled as marker + words on the chain at
    // marker edge = max(accept edge + 1, previous frame end + 2).
    int  n = 0;
    int  cnt = 0, pending = 0, accepted = 0, sent = 0, prev_end = -10;
    bit  m_done = 0, m_err = 0;
    int  exp_cfg [int];
    bit  pop_at [int];
    bit  busy_at [int];
    bit  end_at [int];
    int  cur_q [$];

    initial begin
        forever begin
            bit exp_ready, idle, go_err, do_push;
            int m;
            @(negedge clk);
            exp_ready = !rst && !m_done && !m_err && cnt < FIFO_D && accepted < N_FRAMES;
            chk("cfg_o", int'(cfg_o), exp_cfg.exists(n) ? exp_cfg[n] : 0);
            chk("busy", int'(busy), int'(busy_at.exists(n)));
            chk("done", int'(done), int'(m_done));
            chk("err", int'(err), int'(m_err));
            chk("frames_sent", int'(frames_sent), sent);
            chk("in_ready", int'(in_ready), int'(exp_ready));
            if (rst) begin
                cnt = 0; pending = 0; accepted = 0; sent = 0; prev_end = -10;
                m_done = 0; m_err = 0;
                exp_cfg.delete(); pop_at.delete(); busy_at.delete(); end_at.delete();
                cur_q.delete();
            end else begin
                idle    = !m_done && !m_err && !busy_at.exists(n);
                go_err  = idle && cnt == FIFO_D && pending == 0;
                do_push = in_valid && exp_ready;
                if (end_at.exists(n + 1)) begin
                    pending--;
                    if (sent < N_FRAMES) sent++;
                    if (sent == N_FRAMES) m_done = 1;
                end
                if (do_push) cnt++;
                if (pop_at.exists(n + 1)) cnt--;
                if (go_err) m_err = 1;
                if (do_push) begin
                    cur_q.push_back(int'(in_data));
                    if (in_last) begin
                        accepted++;
                        pending++;
                        m = (n + 2 > prev_end + 2) ? n + 2 : prev_end + 2;
                        exp_cfg[m] = 1;
                        for (int i = 0; i < cur_q.size(); i++) begin
                            exp_cfg[m + 1 + i] = cur_q[i];
                            pop_at[m + 1 + i]  = 1;
                            busy_at[m + i]     = 1;
                        end
                        prev_end = m + cur_q.size();
                        end_at[prev_end] = 1;
                        cur_q.delete();
                    end
                end
            end
            n++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [CFG_W-1:0] d, input bit last);
        bit ok;
        ok = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("push_handshake", int'(ok), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 0);
        step();
        @(negedge clk);
        chk("rst_cfg_o", int'(cfg_o), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_frames_sent", int'(frames_sent), 0);
        step();
        rst = 1'b0;
    endtask

    // Consecutive cfg_o values starting at the next falling edge.
    task automatic expect_seq(input string name, input int vals [$]);
        foreach (vals[i]) begin
            @(negedge clk);
            chk(name, int'(cfg_o), vals[i]);
        end
        step();
    endtask

    task automatic wait_done();
        bit seen;
        seen = 0;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("done_reached", int'(seen), 1);
        chk("done_frames_sent", int'(frames_sent), N_FRAMES);
        chk("done_in_ready", int'(in_ready), 0);
        step();
    endtask

    initial begin
        int seq [$];
        do_reset();

        // Single frame 5, A, 1.
        push_word(4'h5, 0);
        push_word(4'hA, 0);
        push_word(4'h1, 1);
        seq = '{0, 1, 5, 10, 1, 0};
        expect_seq("single_frame", seq);
        chk("single_frames_sent", int'(frames_sent), 1);

        // Stalled host: 4 idle cycles between words.
        push_word(4'h9, 0);
        repeat (4) step();
        push_word(4'h1, 0);
        repeat (4) step();
        push_word(4'h6, 1);
        seq = '{0, 1, 9, 1, 6, 0};
        expect_seq("stalled_host", seq);

        // Back-to-back frames 3,4 and 7,8 completing the bitstream.
        push_word(4'h3, 0);
        push_word(4'h4, 1);
        push_word(4'h7, 0);
        push_word(4'h8, 1);
        seq = '{3, 4, 0, 1, 7, 8};
        expect_seq("back_to_back", seq);
        wait_done();

        // Overflow: FIFO_D words without a last flag.
        do_reset();
        for (int i = 0; i < FIFO_D; i++) push_word(CFG_W'(i + 2), 0);
        @(negedge clk);
        chk("ovf_ready_full", int'(in_ready), 0);
        step();
        @(negedge clk);
        chk("ovf_err", int'(err), 1);
        chk("ovf_cfg_o", int'(cfg_o), 0);
        chk("ovf_frames_sent", int'(frames_sent), 0);
        step();
        repeat (5) step();

        // Backpressure: 6-word frame then 4-word frame pushed without pause.
        do_reset();
        for (int i = 0; i < 6; i++) push_word(CFG_W'(i + 3), i == 5);
        for (int i = 0; i < 4; i++) push_word(CFG_W'(15 - i), i == 3);
        repeat (20) step();

        // Reset after 2 of 5 words have left the chain, then replay.
        do_reset();
        for (int i = 0; i < 5; i++) push_word(CFG_W'(i + 2), i == 4);
        step();
        step();
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_send_word", int'(cfg_o), 3);
        step();
        @(negedge clk);
        chk("mid_rst_cfg_o", int'(cfg_o), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_frames_sent", int'(frames_sent), 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) push_word(CFG_W'(12 + i), i == 2);
        seq = '{0, 1, 12, 13, 14, 0};
        expect_seq("replay", seq);

        // Random bitstreams: random lengths, words, and host gaps.
        for (int r = 0; r < 8; r++) begin
            do_reset();
            for (int f = 0; f < N_FRAMES; f++) begin
                int len;
                len = $urandom_range(1, FIFO_D);
                for (int w = 0; w < len; w++) begin
                    push_word(CFG_W'($urandom), w == len - 1);
                    if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) step();
                end
                if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 10)) step();
            end
            wait_done();
            repeat (3) step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, %0d checks, %0d errors",
                 checks, errors);
        $fatal(1, "timeout");
    end

endmodule
